sha_digest_serializer: RTL and testbench



---
 rtl/sha_digest_ser_pkg.sv | 19 +
 rtl/sha_ser_edge_det.sv | 22 ++
 rtl/sha_digest_serializer.sv | 138 +++++++++++++
 tb/tb_sha_digest_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_digest_ser_pkg.sv
// Shared types and helpers for the SHA digest serializer.
// Holds the state encoding, default geometry and the byte-swap helper.
package sha_digest_ser_pkg;

  localparam int SHA_DIGEST_WORDS = 8;
  localparam int SHA_WORD_W       = 32;

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } ser_state_t;

  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha_ser_edge_det.sv
// Registered rising-edge detector for the PIO advance strobe.
// The rise output is combinational from the live input and the registered copy.
module sha_ser_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/sha_digest_serializer.sv
// Captures a SHA digest and presents it one word at a time to a PIO.
// Define SHA_DIGEST_SER_BSWAP_EN to byte-swap each presented word.
module sha_digest_serializer
  import sha_digest_ser_pkg::*;
#(
  parameter int NUM_WORDS = SHA_DIGEST_WORDS,
  parameter int WORD_W    = SHA_WORD_W,
  localparam int DW       = NUM_WORDS * WORD_W,
  localparam int IW       = (NUM_WORDS > 1) ?
                            $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DW-1:0]     digest_in,
  input  logic              digest_valid,
  output logic              digest_ready,
  input  logic              next_req,
  input  logic              clear,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [IW-1:0]     word_idx,
  output logic              done,
  output logic              overrun
);

  localparam logic [IW-1:0] LAST_IDX =
    IW'(NUM_WORDS - 1);

  ser_state_t        state_q, state_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic [DW-1:0]     hold_nx;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              next_rise;

  function automatic logic [WORD_W-1:0] fmt(
    input logic [WORD_W-1:0] w
  );
`ifdef SHA_DIGEST_SER_BSWAP_EN
    return bswap32(w);
`else
    return w;
`endif
  endfunction

  sha_ser_edge_det u_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .sig_i  (next_req),
    .rise_o (next_rise)
  );

  // Holding register shifts left so the current word is always the MS slice.
  assign hold_nx = hold_q << WORD_W;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (clear) begin
      state_d = EMPTY;
      hold_d  = '0;
      word_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (digest_valid) begin
            state_d = PRESENT;
            hold_d  = digest_in;
            word_d  = fmt(digest_in[DW-1 -: WORD_W]);
            idx_d   = '0;
            valid_d = 1'b1;
          end
        end
        PRESENT: begin
          if (digest_valid) begin
            ovr_d = 1'b1;
          end
          if (next_rise) begin
            if (idx_q == LAST_IDX) begin
              state_d = EMPTY;
              hold_d  = '0;
              word_d  = '0;
              idx_d   = '0;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              hold_d  = hold_nx;
              word_d  = fmt(hold_nx[DW-1 -: WORD_W]);
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign digest_ready = (state_q == EMPTY);
  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign word_idx     = idx_q;
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_sha_digest_serializer.sv
// Directed table-driven bench for sha_digest_serializer.
// Honours SHA_DIGEST_SER_BSWAP_EN for the expected word view.
module tb_sha_digest_serializer;

  logic         clk;
  logic         reset_n;
  logic [255:0] digest_in;
  logic         digest_valid;
  logic         digest_ready;
  logic         next_req;
  logic         clear;
  logic [31:0]  word_out;
  logic         word_valid;
  logic [2:0]   word_idx;
  logic         done;
  logic         overrun;

  int n_run;
  int n_fail;

  sha_digest_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .digest_in    (digest_in),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .next_req     (next_req),
    .clear        (clear),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_idx     (word_idx),
    .done         (done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] H [8] = '{
    32'h6A09E667, 32'hBB67AE85,
    32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C,
    32'h1F83D9AB, 32'h5BE0CD19
  };

  logic [255:0] D1 = {
    32'h6A09E667, 32'hBB67AE85,
    32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C,
    32'h1F83D9AB, 32'h5BE0CD19
  };

  logic [255:0] D2 = {
    32'h11111111, 32'h22222222,
    32'h33333333, 32'h44444444,
    32'h55555555, 32'h66666666,
    32'h77777777, 32'h88888888
  };

  typedef struct {
    logic        dv;
    logic        dsel;
    logic        nr;
    logic        clr;
    logic        v;
    logic [31:0] w;
    logic [2:0]  i;
    logic        dn;
    logic        ov;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ew(int k);
    logic [31:0] w;
    w = H[k];
`ifdef SHA_DIGEST_SER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic vec_t mk(
    logic dv, logic dsel, logic nr, logic clr,
    logic v, int k, logic dn, logic ov
  );
    vec_t r;
    r.dv   = dv;
    r.dsel = dsel;
    r.nr   = nr;
    r.clr  = clr;
    r.v    = v;
    r.w    = v ? ew(k) : 32'h0;
    r.i    = v ? 3'(k) : 3'd0;
    r.dn   = dn;
    r.ov   = ov;
    r.rdy  = ~v;
    return r;
  endfunction

  task automatic add(vec_t r);
    tbl.push_back(r);
  endtask

  task automatic cap(logic ov);
    add(mk(1, 0, 0, 0, 1, 0, 0, ov));
  endtask

  task automatic adv(int from, int to, logic ov);
    for (int k = from + 1; k <= to; k++) begin
      add(mk(0, 0, 1, 0, 1, k, 0, ov));
      add(mk(0, 0, 0, 0, 1, k, 0, ov));
    end
  endtask

  task automatic chk(
    string tag, int row, logic [31:0] act, logic [31:0] exp
  );
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row%0d %s got %h want %h",
               row, tag, act, exp);
    end
  endtask

  task automatic chk_all(int row, vec_t r);
    chk("word_valid", row, 32'(word_valid), 32'(r.v));
    chk("word_out", row, word_out, r.w);
    chk("word_idx", row, 32'(word_idx), 32'(r.i));
    chk("done", row, 32'(done), 32'(r.dn));
    chk("overrun", row, 32'(overrun), 32'(r.ov));
    chk("digest_ready", row, 32'(digest_ready), 32'(r.rdy));
  endtask

  task automatic apply(int row, vec_t r);
    digest_valid = r.dv;
    digest_in    = r.dsel ? D2 : D1;
    next_req     = r.nr;
    clear        = r.clr;
    @(posedge clk);
    #1;
    chk_all(row, r);
  endtask

  initial begin
    n_run        = 0;
    n_fail       = 0;
    reset_n      = 1'b1;
    digest_valid = 1'b0;
    digest_in    = '0;
    next_req     = 1'b0;
    clear        = 1'b0;
    #2 reset_n   = 1'b0;
    #1;
    chk_all(900, mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // A: full walk through all eight words
    cap(0);
    adv(0, 7, 0);
    add(mk(0, 0, 1, 0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // B: next_req held high advances once
    cap(0);
    for (int k = 0; k < 10; k++)
      add(mk(0, 0, 1, 0, 1, 1, 0, 0));
    add(mk(0, 0, 0, 0, 1, 1, 0, 0));
    add(mk(0, 0, 0, 1, 0, 0, 0, 0));
    // C: overrun at word 3, then clear
    cap(0);
    adv(0, 3, 0);
    add(mk(1, 1, 0, 0, 1, 3, 0, 1));
    adv(3, 4, 1);
    add(mk(0, 0, 0, 1, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // D: clear beats last advance and digest
    cap(0);
    adv(0, 7, 0);
    add(mk(1, 1, 1, 1, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0));
    add(mk(0, 0, 1, 0, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // E: last advance with digest_valid
    cap(0);
    adv(0, 7, 0);
    add(mk(1, 1, 1, 0, 0, 0, 1, 1));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1));
    add(mk(1, 1, 0, 1, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[n]) apply(n, tbl[n]);

    // Asynchronous reset mid-digest
    apply(1000, mk(1, 0, 0, 0, 1, 0, 0, 0));
    apply(1001, mk(0, 0, 1, 0, 1, 1, 0, 0));
    apply(1002, mk(1, 1, 0, 0, 1, 1, 0, 1));
    next_req     = 1'b1;
    digest_valid = 1'b0;
    #2 reset_n   = 1'b0;
    #1;
    chk_all(1003, mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // next_req high across reset release is not an advance
    apply(1004, mk(0, 0, 1, 0, 0, 0, 0, 0));
    apply(1005, mk(1, 0, 1, 0, 1, 0, 0, 0));
    apply(1006, mk(0, 0, 1, 0, 1, 0, 0, 0));
    apply(1007, mk(0, 0, 0, 0, 1, 0, 0, 0));
    apply(1008, mk(0, 0, 1, 0, 1, 1, 0, 0));
    apply(1009, mk(0, 0, 0, 0, 1, 1, 0, 0));

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
